// File: rtl/serial_adder_4bit.sv
// Bit-serial LSB-first adder: one full-adder cell and a carry flop, one bit per clock.
// Computes {cout, sum} = a + b + cin over WIDTH+1 cycles; the result is held until
// the next completed operation overwrites it.
module serial_adder_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               bit_s;
    logic               bit_c;

    // Full-adder cell operating on the current LSBs and the running carry
    always_comb begin
        bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        bit_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    end

    // State and datapath registers; reset clears everything so no X reaches the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath control: latch on accepted start, shift one bit per SHIFT cycle
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                carry_d = bit_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Final bit: publish the completed word directly from the cell output
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status and result outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Directed and randomized checks of serial_adder_4bit against plain-arithmetic expectations.
module tb_serial_adder_4bit;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int unsigned  nvec;
    int unsigned  nfail;

    // Reference result currently expected on {cout, sum}
    logic [W-1:0] m_sum;
    logic         m_cout;

    serial_adder_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: pulse (or, with garbage=1, hold) start, check latency, held result,
    // final result, and the single-cycle done pulse.
    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic cin_v, input bit garbage);
        logic [W:0]  e;
        int unsigned cycles;
        bit          seen;
        e = {1'b0, a_v} + {1'b0, b_v} + (W+1)'(cin_v);
        @(negedge clk);
        a = a_v; b = b_v; cin = cin_v; start = 1'b1;
        @(posedge clk);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < W + 4) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                check("busy_in_op", 32'(busy), 32'd1);
                check("result_held", 32'({cout, sum}), 32'({m_cout, m_sum}));
                if (garbage) begin
                    start = 1'b1;
                    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        check("latency", cycles, W + 1);
        check("sum", 32'(sum), 32'(e[W-1:0]));
        check("cout", 32'(cout), 32'(e[W]));
        m_sum  = e[W-1:0];
        m_cout = e[W];
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("result_stable", 32'({cout, sum}), 32'({m_cout, m_sum}));
    endtask

    initial begin
        int unsigned gap;
        bit          got;
        nvec   = 0;
        nfail  = 0;
        m_sum  = '0;
        m_cout = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_sum", 32'({cout, sum}), 32'd0);

        // Directed operands
        run_op(4'b0011, 4'b0011, 1'b0, 1'b0);
        run_op(4'b1111, 4'b0101, 1'b0, 1'b0);
        run_op(4'b0000, 4'b1111, 1'b0, 1'b0);
        run_op(4'b0111, 4'b1000, 1'b1, 1'b0);
        run_op(4'b0110, 4'b1100, 1'b1, 1'b0);
        run_op(4'b1111, 4'b1111, 1'b1, 1'b0);

        // Start held with changing operands while busy
        run_op(4'b1010, 4'b0110, 1'b0, 1'b1);
        run_op(4'b0001, 4'b0010, 1'b1, 1'b1);

        // Reset mid-operation
        @(negedge clk);
        a = 4'b1001; b = 4'b0111; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'({cout, sum}), 32'd0);
        m_sum  = '0;
        m_cout = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            check("abort_quiet", 32'({done, busy}), 32'd0);
        end
        run_op(4'b1001, 4'b0111, 1'b1, 1'b0);

        // Back-to-back throughput: start held high, done pulses spaced WIDTH+2 apart
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; cin = 1'b0; start = 1'b1;
        got = 1'b0;
        for (int unsigned i = 0; i < 3 * W && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("first_done_seen", 32'(got), 32'd1);
        gap = 0;
        got = 1'b0;
        while (!got && gap < 3 * W) begin
            @(negedge clk);
            gap++;
            if (done) got = 1'b1;
        end
        check("done_spacing", gap, W + 2);
        check("b2b_sum", 32'({cout, sum}), 32'h08);
        m_sum  = 4'b1000;
        m_cout = 1'b0;
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Randomized operations
        for (int unsigned i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
